hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and pipeline-control unit for the 5-stage pipelined MIPS core.
- Consumes the register specifiers and control bits held in the decode/execute, execute/memory and memory/writeback pipeline registers.
- Drives the stall, flush and forwarding controls back into the pipeline, including the clr input of the decode/execute register.
- Owns the data-memory wait handshake with a timeout monitor, and keeps saturating stall and flush event counters for performance debug.

Parameters:
MEM_TIMEOUT, 16, consecutive frozen cycles waiting on mem_ready before mem_timeout is raised (min 2)
CNT_W, 16, width of the stall and flush event counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
Rs_D, Rt_D  in  5 each  source registers of the instruction in decode
Rs_E, Rt_E  in  5 each  source registers of the instruction in execute
WriteReg_E, WriteReg_M, WriteReg_W  in  5 each  destination register in execute / memory / writeback
RegWrite_E, RegWrite_M, RegWrite_W  in  1 each  register-write enable per stage
MemtoReg_E, MemtoReg_M  in  1 each  load in execute / memory
Branch_D  in  1  branch in decode (compared in decode)
mem_req_M  in  1  load or store in memory stage
mem_ready  in  1  data memory completes the access this cycle
cnt_clr  in  1  synchronous clear of both event counters
StallF, StallD, StallE, StallM  out  1 each  hold PC / D / E / M pipeline registers
FlushE  out  1  to decode/execute register clr; bubble into execute
FlushW  out  1  bubble into writeback
ForwardAD, ForwardBD  out  1 each  decode-stage branch comparator forward from memory stage
ForwardAE, ForwardBE  out  2 each  ALU operand select: 00 register file, 01 writeback, 10 memory
mem_timeout  out  1  sticky memory-timeout error
stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (rst=1, async): state=IDLE, wait_cnt=0, mem_timeout=0, both counters=0. All outputs are forced to 0 while rst=1.
- Register $0 never matches any hazard or forward compare.
- Forwarding (combinational):
  - ForwardAE=10 if RegWrite_M and WriteReg_M==Rs_E.
  - Else ForwardAE=01 if RegWrite_W and WriteReg_W==Rs_E.
  - Else ForwardAE=00.
  - The memory stage has priority over writeback. ForwardBE is the same using Rt_E.
  - ForwardAD = RegWrite_M and WriteReg_M==Rs_D. ForwardBD is the same using Rt_D.
- lwstall = MemtoReg_E and (Rt_E==Rs_D or Rt_E==Rt_D).
- brstall = Branch_D and one of:
  - RegWrite_E and WriteReg_E matches Rs_D or Rt_D, or
  - MemtoReg_M and WriteReg_M matches Rs_D or Rt_D.
- freeze (memory wait) depends on state:
  - IDLE: freeze = mem_req_M and not mem_ready.
  - MEM_WAIT: freeze = not mem_ready.
  - TIMEOUT: freeze = 1.
- Output equations:
  - StallF = StallD = lwstall or brstall or freeze.
  - StallE = StallM = FlushW = freeze.
  - FlushE = (lwstall or brstall) and not freeze. Execute is held, not bubbled, while frozen.
- State machine transitions:
  - IDLE to MEM_WAIT when freeze is high; wait_cnt<=1.
  - MEM_WAIT with mem_ready=1: go to IDLE, wait_cnt<=0. This cycle is not frozen; the access completes.
  - MEM_WAIT with mem_ready=0: wait_cnt<=wait_cnt+1. If wait_cnt+1==MEM_TIMEOUT, go to TIMEOUT and set mem_timeout<=1.
  - If mem_ready and the timeout condition coincide, mem_ready wins.
  - TIMEOUT is terminal: the pipeline stays frozen and mem_timeout stays 1 until rst.
- Counters:
  - stall_cnt increments on every cycle StallF=1.
  - flush_cnt increments on every cycle FlushE=1.
  - Both saturate at all-ones.
  - cnt_clr=1 zeroes both on the next edge; clear beats increment.
- A reset asserted mid-wait returns the block to IDLE immediately and drops all stalls.

Test Plan:
1. Forwarding: RegWrite_M=1, WriteReg_M=8; RegWrite_W=1, WriteReg_W=8; Rs_E=8 -> ForwardAE=10. Drop RegWrite_M -> ForwardAE=01. Same with all regs=0 -> 00.
2. Load-use: MemtoReg_E=1, Rt_E=9, Rs_D=9 -> StallF=StallD=FlushE=1, StallE=0 for one cycle. flush_cnt 0->1, stall_cnt 0->1.
3. Branch: Branch_D=1, Rs_D=4, MemtoReg_M=1, WriteReg_M=4 -> StallD=1, FlushE=1. Next cycle RegWrite_M=1, WriteReg_M=4 with load moved on -> ForwardAD=1, no stall.
4. Memory wait: mem_req_M=1, mem_ready=0 for 3 cycles then 1 -> StallF..StallM=FlushW=1 for exactly 3 cycles, FlushE=0 even with lwstall true, state returns to IDLE, mem_timeout=0.
5. Timeout: mem_ready held 0 with MEM_TIMEOUT=16 -> mem_timeout rises at the edge ending the 16th frozen cycle and stays frozen. A later mem_ready=1 has no effect. rst=1 -> all outputs 0 immediately.
6. Counters: force 2^CNT_W+5 stall cycles -> stall_cnt=all-ones. cnt_clr=1 concurrent with a stall -> 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS core: forwarding, load/branch
// interlocks, data-memory wait handshake with timeout, and stall/flush event counters.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs_D,
    input  logic [4:0]       Rt_D,
    input  logic [4:0]       Rs_E,
    input  logic [4:0]       Rt_E,
    input  logic [4:0]       WriteReg_E,
    input  logic [4:0]       WriteReg_M,
    input  logic [4:0]       WriteReg_W,
    input  logic             RegWrite_E,
    input  logic             RegWrite_M,
    input  logic             RegWrite_W,
    input  logic             MemtoReg_E,
    input  logic             MemtoReg_M,
    input  logic             Branch_D,
    input  logic             mem_req_M,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushE,
    output logic             FlushW,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        MEM_WAIT,
        TIMEOUT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_next;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout_next;
    logic              freeze;
    logic              lwstall;
    logic              brstall;

    // Register $0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    assign wait_inc = wait_cnt + 1'b1;

    always_comb begin
        lwstall = MemtoReg_E && (reg_match(Rt_E, Rs_D) || reg_match(Rt_E, Rt_D));
        brstall = Branch_D &&
                  ((RegWrite_E && (reg_match(WriteReg_E, Rs_D) || reg_match(WriteReg_E, Rt_D))) ||
                   (MemtoReg_M && (reg_match(WriteReg_M, Rs_D) || reg_match(WriteReg_M, Rt_D))));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_next;
            mem_timeout <= timeout_next;
        end
    end

    // A completing access wins over the timeout in the same cycle; TIMEOUT only leaves on rst.
    always_comb begin
        state_next   = state;
        wait_next    = wait_cnt;
        timeout_next = mem_timeout;
        case (state)
            IDLE: begin
                if (mem_req_M && !mem_ready) begin
                    state_next = MEM_WAIT;
                    wait_next  = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next = IDLE;
                    wait_next  = '0;
                end else begin
                    wait_next = wait_inc;
                    if (wait_inc == WAIT_LAST) begin
                        state_next   = TIMEOUT;
                        timeout_next = 1'b1;
                    end
                end
            end
            TIMEOUT: begin
                timeout_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
                wait_next  = '0;
            end
        endcase
    end

    // Execute is held rather than bubbled while frozen, so FlushE yields to freeze.
    always_comb begin
        freeze    = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        case (state)
            IDLE:     freeze = mem_req_M && !mem_ready;
            MEM_WAIT: freeze = !mem_ready;
            TIMEOUT:  freeze = 1'b1;
            default:  freeze = 1'b0;
        endcase
        if (!rst) begin
            StallF = lwstall || brstall || freeze;
            StallD = lwstall || brstall || freeze;
            StallE = freeze;
            StallM = freeze;
            FlushW = freeze;
            FlushE = (lwstall || brstall) && !freeze;

            if (RegWrite_M && reg_match(WriteReg_M, Rs_E)) begin
                ForwardAE = 2'b10;
            end else if (RegWrite_W && reg_match(WriteReg_W, Rs_E)) begin
                ForwardAE = 2'b01;
            end

            if (RegWrite_M && reg_match(WriteReg_M, Rt_E)) begin
                ForwardBE = 2'b10;
            end else if (RegWrite_W && reg_match(WriteReg_W, Rt_E)) begin
                ForwardBE = 2'b01;
            end

            ForwardAD = RegWrite_M && reg_match(WriteReg_M, Rs_D);
            ForwardBD = RegWrite_M && reg_match(WriteReg_M, Rt_D);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallF && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (FlushE && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table plus hand-written memory-wait,
// timeout, counter-saturation and mid-wait reset sequences, checked via a scoreboard queue.
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 8;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       sf, sd, se, sm, fe, fw, fad, fbd;
        logic [1:0] fae, fbe;
        logic       to;
    } out_t;

    typedef struct {
        string      name;
        logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
        logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, mreq, mrdy, clr;
        out_t       exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       Rs_D, Rt_D, Rs_E, Rt_E, WriteReg_E, WriteReg_M, WriteReg_W;
    logic             RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M, Branch_D;
    logic             mem_req_M, mem_ready, cnt_clr;
    logic             StallF, StallD, StallE, StallM, FlushE, FlushW, ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    out_t             act;

    int   errors = 0;
    int   checks = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;
    vec_t sb[$];
    vec_t tbl[$];

    hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .Rs_D(Rs_D), .Rt_D(Rt_D), .Rs_E(Rs_E), .Rt_E(Rt_E),
        .WriteReg_E(WriteReg_E), .WriteReg_M(WriteReg_M), .WriteReg_W(WriteReg_W),
        .RegWrite_E(RegWrite_E), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .MemtoReg_E(MemtoReg_E), .MemtoReg_M(MemtoReg_M), .Branch_D(Branch_D),
        .mem_req_M(mem_req_M), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushE(FlushE), .FlushW(FlushW), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign act = {StallF, StallD, StallE, StallM, FlushE, FlushW,
                  ForwardAD, ForwardBD, ForwardAE, ForwardBE, mem_timeout};

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected bits: {StallF/D, freeze (StallE/M, FlushW), FlushE, ForwardAD, ForwardBD, mem_timeout}
    function automatic out_t mkExp(input logic [5:0] b, input logic [1:0] fae, input logic [1:0] fbe);
        out_t o;
        o.sf  = b[5];
        o.sd  = b[5];
        o.se  = b[4];
        o.sm  = b[4];
        o.fw  = b[4];
        o.fe  = b[3];
        o.fad = b[2];
        o.fbd = b[1];
        o.to  = b[0];
        o.fae = fae;
        o.fbe = fbe;
        return o;
    endfunction

    // Control bits: {RegWrite_E, RegWrite_M, RegWrite_W, MemtoReg_E, MemtoReg_M, Branch_D, mem_req_M, mem_ready}
    function automatic vec_t mkVec(input string name,
                                   input logic [4:0] rs_d, input logic [4:0] rt_d,
                                   input logic [4:0] rs_e, input logic [4:0] rt_e,
                                   input logic [4:0] wr_e, input logic [4:0] wr_m,
                                   input logic [4:0] wr_w, input logic [7:0] ctl,
                                   input out_t exp);
        vec_t v;
        v.name  = name;
        v.rs_d  = rs_d;
        v.rt_d  = rt_d;
        v.rs_e  = rs_e;
        v.rt_e  = rt_e;
        v.wr_e  = wr_e;
        v.wr_m  = wr_m;
        v.wr_w  = wr_w;
        v.rw_e  = ctl[7];
        v.rw_m  = ctl[6];
        v.rw_w  = ctl[5];
        v.m2r_e = ctl[4];
        v.m2r_m = ctl[3];
        v.br_d  = ctl[2];
        v.mreq  = ctl[1];
        v.mrdy  = ctl[0];
        v.clr   = 1'b0;
        v.exp   = exp;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Rs_D       = v.rs_d;
        Rt_D       = v.rt_d;
        Rs_E       = v.rs_e;
        Rt_E       = v.rt_e;
        WriteReg_E = v.wr_e;
        WriteReg_M = v.wr_m;
        WriteReg_W = v.wr_w;
        RegWrite_E = v.rw_e;
        RegWrite_M = v.rw_m;
        RegWrite_W = v.rw_w;
        MemtoReg_E = v.m2r_e;
        MemtoReg_M = v.m2r_m;
        Branch_D   = v.br_d;
        mem_req_M  = v.mreq;
        mem_ready  = v.mrdy;
        cnt_clr    = v.clr;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
    endtask

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    // Compares this cycle's outputs, then advances the counter model across the coming edge.
    task automatic checkOutput;
        vec_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
            checkValue({e.name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
            checkValue({e.name, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
            if (rst || e.clr) begin
                exp_stall = 0;
                exp_flush = 0;
            end else begin
                if (e.exp.sf && exp_stall != CNT_MAX) exp_stall++;
                if (e.exp.fe && exp_flush != CNT_MAX) exp_flush++;
            end
        end
    endtask

    initial begin
        vec_t v;
        vec_t nop;
        nop = mkVec("nop", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000000,
                    mkExp(6'b000000, 2'b00, 2'b00));

        // Reset with a load-use hazard and forward sources present: everything must read 0.
        rst = 1'b1;
        v = mkVec("reset", 5'd9, 5'd0, 5'd8, 5'd9, 5'd0, 5'd8, 5'd8, 8'b01110010,
                  mkExp(6'b000000, 2'b00, 2'b00));
        drive(v);
        sb.push_back(v);
        checkOutput();
        @(posedge clk);
        #1;
        drive(nop);
        rst = 1'b0;

        tbl.push_back(mkVec("fwd_ae_mem",   5'd0,  5'd0,  5'd8, 5'd0,  5'd0,  5'd8,  5'd8, 8'b01100000, mkExp(6'b000000, 2'b10, 2'b00)));
        tbl.push_back(mkVec("fwd_ae_wb",    5'd0,  5'd0,  5'd8, 5'd0,  5'd0,  5'd8,  5'd8, 8'b00100000, mkExp(6'b000000, 2'b01, 2'b00)));
        tbl.push_back(mkVec("fwd_zero",     5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0,  5'd0, 8'b01100000, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("fwd_be_mem",   5'd0,  5'd0,  5'd0, 5'd3,  5'd0,  5'd3,  5'd3, 8'b01100000, mkExp(6'b000000, 2'b00, 2'b10)));
        tbl.push_back(mkVec("fwd_split",    5'd0,  5'd0,  5'd5, 5'd6,  5'd0,  5'd6,  5'd5, 8'b01100000, mkExp(6'b000000, 2'b01, 2'b10)));
        tbl.push_back(mkVec("fwd_no_we",    5'd0,  5'd0,  5'd7, 5'd7,  5'd0,  5'd7,  5'd7, 8'b00000000, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("fwd_decode",   5'd10, 5'd10, 5'd0, 5'd0,  5'd0,  5'd10, 5'd0, 8'b01000000, mkExp(6'b000110, 2'b00, 2'b00)));
        tbl.push_back(mkVec("load_use_rs",  5'd9,  5'd0,  5'd0, 5'd9,  5'd0,  5'd0,  5'd0, 8'b00010000, mkExp(6'b101000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("load_use_rt",  5'd0,  5'd12, 5'd0, 5'd12, 5'd0,  5'd0,  5'd0, 8'b00010000, mkExp(6'b101000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("load_r0",      5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0,  5'd0, 8'b00010000, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("load_nomatch", 5'd4,  5'd5,  5'd0, 5'd9,  5'd0,  5'd0,  5'd0, 8'b00010000, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("br_load_m",    5'd4,  5'd0,  5'd0, 5'd0,  5'd0,  5'd4,  5'd0, 8'b01001100, mkExp(6'b101100, 2'b00, 2'b00)));
        tbl.push_back(mkVec("br_fwd_m",     5'd4,  5'd0,  5'd0, 5'd0,  5'd0,  5'd4,  5'd0, 8'b01000100, mkExp(6'b000100, 2'b00, 2'b00)));
        tbl.push_back(mkVec("br_alu_e",     5'd0,  5'd11, 5'd0, 5'd0,  5'd11, 5'd0,  5'd0, 8'b10000100, mkExp(6'b101000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("alu_e_nobr",   5'd0,  5'd11, 5'd0, 5'd0,  5'd11, 5'd0,  5'd0, 8'b10000000, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("br_e_nowe",    5'd0,  5'd11, 5'd0, 5'd0,  5'd11, 5'd0,  5'd0, 8'b00000100, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("br_r0",        5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0,  5'd0, 8'b10000100, mkExp(6'b000000, 2'b00, 2'b00)));
        tbl.push_back(mkVec("mem_ready_now",5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  5'd0,  5'd0, 8'b00000011, mkExp(6'b000000, 2'b00, 2'b00)));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i]);
            checkOutput();
        end

        // Memory wait of three cycles with a load-use hazard pending: execute held, not flushed.
        v = mkVec("mem_wait", 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 8'b00010010,
                  mkExp(6'b110000, 2'b00, 2'b00));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(v);
            checkOutput();
        end
        v = mkVec("mem_done", 5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 8'b00010011,
                  mkExp(6'b101000, 2'b00, 2'b00));
        applyStimulus(v);
        checkOutput();
        v = nop;
        v.name = "mem_back_idle";
        applyStimulus(v);
        checkOutput();

        // Timeout: 16 frozen cycles, flag rises at the edge ending the 16th, then stays frozen.
        v = mkVec("timeout_wait", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000010,
                  mkExp(6'b110000, 2'b00, 2'b00));
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            applyStimulus(v);
            checkOutput();
        end
        v = mkVec("timeout_set", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000010,
                  mkExp(6'b110001, 2'b00, 2'b00));
        applyStimulus(v);
        checkOutput();
        v = mkVec("timeout_ready", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000001,
                  mkExp(6'b110001, 2'b00, 2'b00));
        applyStimulus(v);
        checkOutput();

        // The frozen pipeline stalls every cycle, driving stall_cnt into saturation.
        v = mkVec("cnt_sat", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000000,
                  mkExp(6'b110001, 2'b00, 2'b00));
        for (int i = 0; i < CNT_MAX + 6; i++) begin
            applyStimulus(v);
            checkOutput();
        end
        checkValue("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));

        v.name = "cnt_clr";
        v.clr  = 1'b1;
        applyStimulus(v);
        checkOutput();
        v.name = "cnt_after_clr";
        v.clr  = 1'b0;
        applyStimulus(v);
        checkOutput();
        applyStimulus(v);
        checkOutput();

        // Asynchronous reset mid-timeout: outputs drop without waiting for a clock edge.
        #2;
        rst = 1'b1;
        drive(nop);
        #1;
        checkValue("async_reset_outputs", 32'(act), 32'd0);
        checkValue("async_reset_stall_cnt", 32'(stall_cnt), 32'd0);
        checkValue("async_reset_flush_cnt", 32'(flush_cnt), 32'd0);
        exp_stall = 0;
        exp_flush = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        v = nop;
        v.name = "post_reset_idle";
        applyStimulus(v);
        checkOutput();
        v = mkVec("post_reset_wait", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000010,
                  mkExp(6'b110000, 2'b00, 2'b00));
        applyStimulus(v);
        checkOutput();
        v = mkVec("post_reset_done", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 8'b00000011,
                  mkExp(6'b000000, 2'b00, 2'b00));
        applyStimulus(v);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
